// File: rtl/conv_acc_requant_pkg.sv
// Fixed-point constants shared by the MAC chain and the requantizer.
// Operands are Q7.8 in 16 bits; accumulators grow with the convolution size.
package conv_acc_requant_pkg;

    localparam int FXP_FRAC_BITS = 8;
    localparam int FXP_DATA_W    = 16;

    localparam logic [FXP_DATA_W-1:0] SAT_MAX       = 16'h7FFF;
    localparam logic [FXP_DATA_W-1:0] SAT_MIN       = 16'h8000;
    localparam logic [15:0]           SAT_COUNT_MAX = 16'hFFFF;

    // Product of two 16-bit operands is 32 bits; summing N of them needs clog2(N+1) guard bits.
    function automatic int acc_w(input int convol_size);
        return 32 + $clog2(convol_size + 1);
    endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// Combinational fixed-point helpers: round-half-up shift of the accumulator,
// and ReLU plus clip of the shifted value to the 16-bit output format.
module fxp_round_sat
    import conv_acc_requant_pkg::*;
#(
    parameter int ACC_W     = 36,
    parameter int FRAC_BITS = FXP_FRAC_BITS
) (
    input  logic [ACC_W-1:0]      acc_i,
    output logic [ACC_W:0]        r_o,
    input  logic [ACC_W:0]        r_i,
    input  logic                  relu_i,
    output logic [FXP_DATA_W-1:0] data_o,
    output logic                  sat_o
);

    localparam logic [ACC_W:0] HALF  = {{ACC_W{1'b0}}, 1'b1} << (FRAC_BITS - 1);
    localparam logic [ACC_W:0] R_MAX = {{(ACC_W + 1 - FXP_DATA_W){1'b0}}, SAT_MAX};
    localparam logic [ACC_W:0] R_MIN = {{(ACC_W + 1 - FXP_DATA_W){1'b1}}, SAT_MIN};

    logic signed [ACC_W:0] acc_ext;
    logic signed [ACC_W:0] sum_rnd;
    logic signed [ACC_W:0] r_s;

    // One extra bit of headroom so adding the half-LSB can never wrap.
    assign acc_ext = $signed({acc_i[ACC_W-1], acc_i});
    assign sum_rnd = acc_ext + $signed(HALF);
    assign r_o     = sum_rnd >>> FRAC_BITS;

    assign r_s = $signed(r_i);

    always_comb begin
        data_o = r_i[FXP_DATA_W-1:0];
        sat_o  = 1'b0;
        if (relu_i && r_s[ACC_W]) begin
            data_o = '0;
        end else if (r_s > $signed(R_MAX)) begin
            data_o = SAT_MAX;
            sat_o  = 1'b1;
        end else if (r_s < $signed(R_MIN)) begin
            data_o = SAT_MIN;
            sat_o  = 1'b1;
        end
    end

endmodule

// File: rtl/conv_acc_requant.sv
// Two-stage requantizer for convolution accumulator sums: S1 rounds and shifts,
// S2 applies ReLU/saturation; a single global enable provides backpressure.
module conv_acc_requant
    import conv_acc_requant_pkg::*;
#(
    parameter int  Convol_Size = 9,
    parameter int  FRAC_BITS   = FXP_FRAC_BITS,
    localparam int ACC_W       = acc_w(Convol_Size)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ACC_W-1:0]      in_acc,
    input  logic                  in_relu,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [FXP_DATA_W-1:0] out_data,
    output logic                  out_sat,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [15:0]           sat_count,
    input  logic                  sat_clr
);

    logic                  en;

    logic                  s1_valid_q, s1_valid_d;
    logic [ACC_W:0]        s1_r_q, s1_r_d;
    logic                  s1_relu_q, s1_relu_d;

    logic                  out_valid_q, out_valid_d;
    logic [FXP_DATA_W-1:0] out_data_q, out_data_d;
    logic                  out_sat_q, out_sat_d;
    logic [15:0]           sat_count_q, sat_count_d;

    logic [ACC_W:0]        r_rnd;
    logic [FXP_DATA_W-1:0] sat_data;
    logic                  sat_flag;

    fxp_round_sat #(
        .ACC_W     (ACC_W),
        .FRAC_BITS (FRAC_BITS)
    ) u_fxp (
        .acc_i  (in_acc),
        .r_o    (r_rnd),
        .r_i    (s1_r_q),
        .relu_i (s1_relu_q),
        .data_o (sat_data),
        .sat_o  (sat_flag)
    );

    // The whole pipe moves together: it stalls only while a finished beat waits downstream.
    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_r_d      = s1_r_q;
        s1_relu_d   = s1_relu_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        sat_count_d = sat_count_q;

        if (en) begin
            s1_valid_d  = in_valid;
            out_valid_d = s1_valid_q;
            if (in_valid) begin
                s1_r_d    = r_rnd;
                s1_relu_d = in_relu;
            end
            if (s1_valid_q) begin
                out_data_d = sat_data;
                out_sat_d  = sat_flag;
            end
        end

        if (sat_clr) begin
            sat_count_d = '0;
        end else if (out_valid_q && out_ready && out_sat_q && (sat_count_q != SAT_COUNT_MAX)) begin
            sat_count_d = sat_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            sat_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            sat_count_q <= sat_count_d;
        end
    end

    // Intermediate data carries no reset; its valid bit qualifies it.
    always_ff @(posedge clk) begin
        s1_r_q    <= s1_r_d;
        s1_relu_q <= s1_relu_d;
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign sat_count = sat_count_q;

endmodule

// File: tb/tb_conv_acc_requant.sv
// Bench for conv_acc_requant: directed literal cases plus randomized traffic
// checked every cycle against an arithmetic reference model.
`timescale 1ns/1ps
module tb_conv_acc_requant;
    import conv_acc_requant_pkg::*;

    localparam int ACC_W = acc_w(9);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [ACC_W-1:0] in_acc = '0;
    logic             in_relu = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [15:0]      out_data;
    logic             out_sat;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [15:0]      sat_count;
    logic             sat_clr = 1'b0;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [15:0] d;
        logic        s;
    } exp_t;

    exp_t q[$];
    int   mdl_cnt  = 0;
    logic prev_rst = 1'b1;

    conv_acc_requant dut (
        .clk       (clk),
        .rst       (rst),
        .in_acc    (in_acc),
        .in_relu   (in_relu),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sat_count (sat_count),
        .sat_clr   (sat_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: floor((acc + 128) / 256), then ReLU and clip to int16.
    function automatic exp_t model(input logic [ACC_W-1:0] acc, input logic relu);
        exp_t   e;
        longint v;
        longint r;
        v = longint'($signed(acc)) + 128;
        if (v >= 0) r = v / 256;
        else        r = (v - 255) / 256;
        e.s = 1'b0;
        if (relu && r < 0)      e.d = 16'h0000;
        else if (r > 32767)     begin e.d = 16'h7FFF; e.s = 1'b1; end
        else if (r < -32768)    begin e.d = 16'h8000; e.s = 1'b1; end
        else                    e.d = 16'(r);
        return e;
    endfunction

    function automatic logic [ACC_W-1:0] rand_acc();
        logic [63:0] t;
        longint      v;
        t = {$urandom, $urandom};
        case ($urandom_range(0, 3))
            0: v = longint'($urandom_range(0, 131071)) - 65536;
            1: v = 64'sd8388352 + longint'($urandom_range(0, 600)) - 300;
            2: v = -64'sd8388608 + longint'($urandom_range(0, 600)) - 300;
            default: v = longint'(t[ACC_W-1:0]);
        endcase
        return ACC_W'(v);
    endfunction

    // Reference scoreboard, sampled mid-cycle well away from the rising edge.
    always @(negedge clk) begin
        #2;
        if (prev_rst) begin
            chk("reset out_valid", out_valid, 0);
            chk("reset out_data", out_data, 0);
            chk("reset out_sat", out_sat, 0);
            chk("reset sat_count", sat_count, 0);
            chk("reset in_ready", in_ready, 1);
        end
        chk("in_ready rule", in_ready, !out_valid || out_ready);
        chk("sat_count", sat_count, mdl_cnt);
        chk("occupancy<=2", q.size() <= 2, 1);
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("spurious out_valid", out_valid, 0);
            end else begin
                chk("out_data", out_data, q[0].d);
                chk("out_sat", out_sat, q[0].s);
            end
        end
        if (rst) begin
            q.delete();
            mdl_cnt = 0;
        end else begin
            if (out_valid && out_ready && q.size() > 0) begin
                if (q[0].s && mdl_cnt < 65535) mdl_cnt++;
                void'(q.pop_front());
            end
            if (sat_clr) mdl_cnt = 0;
            if (in_valid && in_ready) q.push_back(model(in_acc, in_relu));
        end
        prev_rst = rst;
    end

    task automatic send_one(input longint acc, input logic relu, input logic [15:0] exp_d,
                            input logic exp_s, input string name);
        @(negedge clk);
        in_acc    = ACC_W'(acc);
        in_relu   = relu;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk({name, " early valid"}, out_valid, 0);
        @(negedge clk);
        #1;
        chk({name, " valid"}, out_valid, 1);
        chk({name, " data"}, out_data, exp_d);
        chk({name, " sat"}, out_sat, exp_s);
    endtask

    task automatic backpressure();
        int n;
        int got[$];
        int gcyc[$];
        n = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1;
            in_acc   = ACC_W'((n + 1) * 256);
            #1;
            if (in_ready) n++;
            @(negedge clk);
        end
        chk("bp accepted", n, 2);
        #1;
        chk("bp in_ready low", in_ready, 0);
        @(negedge clk);
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            in_valid = (n < 4);
            in_acc   = ACC_W'((n + 1) * 256);
            #1;
            if (in_valid && in_ready) n++;
            if (out_valid) begin
                got.push_back(int'(out_data));
                gcyc.push_back(c);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("bp out count", got.size(), 4);
        for (int i = 0; i < got.size() && i < 4; i++) chk("bp order", got[i], i + 1);
        if (got.size() == 4) chk("bp no gaps", gcyc[3] - gcyc[0], 3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        send_one(384, 1'b0, 16'h0002, 1'b0, "pos 1.5");
        send_one(-384, 1'b0, 16'hFFFF, 1'b0, "neg 1.5");
        send_one(64'sd8388608, 1'b0, 16'h7FFF, 1'b1, "sat hi");
        @(negedge clk); #1 chk("sat_count after hi", sat_count, 1);
        send_one(-64'sd16777216, 1'b0, 16'h8000, 1'b1, "sat lo");
        @(negedge clk); #1 chk("sat_count after lo", sat_count, 2);
        send_one(-384, 1'b1, 16'h0000, 1'b0, "relu neg");
        send_one(-64'sd16777216, 1'b1, 16'h0000, 1'b0, "relu big neg");
        @(negedge clk); #1 chk("sat_count relu", sat_count, 2);

        @(negedge clk);
        backpressure();
        repeat (3) @(negedge clk);

        // Two beats in flight, then a one-cycle reset.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_acc    = ACC_W'(5 * 256);
        @(negedge clk);
        in_acc = ACC_W'(6 * 256);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post-rst out_valid", out_valid, 0);
        chk("post-rst sat_count", sat_count, 0);
        out_ready = 1'b1;
        send_one(256, 1'b0, 16'h0001, 1'b0, "after rst");
        repeat (2) @(negedge clk);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 9) < 7);
            in_relu   = 1'($urandom_range(0, 1));
            in_acc    = rand_acc();
            out_ready = ($urandom_range(0, 9) < 7);
            sat_clr   = ($urandom_range(0, 99) == 0);
            rst       = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        rst       = 1'b0;
        sat_clr   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);

        in_relu  = 1'b0;
        in_acc   = ACC_W'(64'sd8388608);
        in_valid = 1'b1;
        repeat (65545) @(negedge clk);
        #1;
        chk("sat_count pinned", sat_count, 16'hFFFF);
        chk("clr coincident xfer", out_valid && out_ready && out_sat, 1);
        sat_clr = 1'b1;
        @(negedge clk);
        sat_clr  = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("clr wins", sat_count, 0);
        repeat (5) @(negedge clk);
        chk("drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
